internibble_carry_lookahead_16bit: RTL and testbench



---
 rtl/adder_pkg.sv | 7 +
 rtl/cla_nibble4.sv | 24 ++
 rtl/internibble_carry_lookahead_16bit.sv | 61 ++++++
 tb/tb_internibble_carry_lookahead_16bit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and nibble type for the 16-bit carry-lookahead adder
package adder_pkg;
  localparam int ADDER_WIDTH  = 16;
  localparam int NIBBLE_WIDTH = 4;
  localparam int NUM_NIBBLES  = 4;
  typedef logic [3:0] nibble_t;
endpackage

// File: rtl/cla_nibble4.sv
// cla_nibble4: 4-bit lookahead slice producing the sum plus group generate/propagate
module cla_nibble4
  import adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);
  nibble_t g, p, c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s = p ^ c;
    G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    P = &p;
  end
endmodule

// File: rtl/internibble_carry_lookahead_16bit.sv
// internibble_carry_lookahead_16bit: registered 16-bit adder, four CLA nibbles joined by flat lookahead
// Optional registered signed overflow output enabled by defining CLA_OVERFLOW_EN.
module internibble_carry_lookahead_16bit
  import adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic        ovf
`endif
);
  logic [NUM_NIBBLES-1:0] gg, pp, c4;
  logic [ADDER_WIDTH-1:0] s_d, s_q;
  logic cout_d, cout_q;
  for (genvar k = 0; k < NUM_NIBBLES; k++) begin : g_nib
    cla_nibble4 u_nib (
      .a (A[k*NIBBLE_WIDTH +: NIBBLE_WIDTH]),
      .b (B[k*NIBBLE_WIDTH +: NIBBLE_WIDTH]),
      .ci(c4[k]),
      .s (s_d[k*NIBBLE_WIDTH +: NIBBLE_WIDTH]),
      .G (gg[k]),
      .P (pp[k])
    );
  end
  // Every nibble carry is a flat sum of products so no carry chains through a nibble
  always_comb begin
    c4[0] = cin;
    c4[1] = gg[0] | (pp[0] & cin);
    c4[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    c4[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cin);
    cout_d = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
           | (pp[3] & pp[2] & pp[1] & pp[0] & cin);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end
  assign S    = s_q;
  assign cout = cout_q;
`ifdef CLA_OVERFLOW_EN
  logic ovf_d, ovf_q;
  // Carry into bit 15 is recovered from its sum bit: c15 = p15 ^ s15
  assign ovf_d = (A[15] ^ B[15] ^ s_d[15]) ^ cout_d;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_internibble_carry_lookahead_16bit.sv
// tb_internibble_carry_lookahead_16bit: randomized and directed checks against an arithmetic model
module tb_internibble_carry_lookahead_16bit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        cin;
  logic [15:0] S;
  logic        cout;
  int n_cmp = 0;
  int n_err = 0;
`ifdef CLA_OVERFLOW_EN
  logic ovf;
`endif

  internibble_carry_lookahead_16bit dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .cin (cin),
    .S   (S),
    .cout(cout)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(int'(a) + int'(b) + int'(c));
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sa + sb + int'(c);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    rst = r; A = a; B = b; cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 16'hA5A5, 16'h5A5A, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    n_cmp++;
    if ({cout, S} !== 17'h0) begin
      n_err++;
      $display("FAIL reset: got cout=%b S=%h, want cout=0 S=0000", cout, S);
    end
`ifdef CLA_OVERFLOW_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b, want 0", ovf);
    end
`endif
  endtask

  task automatic test_directed;
    logic [15:0] ta[6] = '{16'd120, 16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] tb[6] = '{16'd7,   16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h7FFF};
    logic        tc[6] = '{1'b1,    1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
    logic [16:0] tw[6] = '{17'h00080, 17'h01000, 17'h10000, 17'h08000, 17'h10000, 17'h10000};
    logic        to[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, ta[i], tb[i], tc[i]);
      n_cmp++;
      if ({cout, S} !== tw[i]) begin
        n_err++;
        $display("FAIL directed%0d: got cout=%b S=%h, want cout=%b S=%h", i, cout, S, tw[i][16], tw[i][15:0]);
      end
`ifdef CLA_OVERFLOW_EN
      n_cmp++;
      if (ovf !== to[i]) begin
        n_err++;
        $display("FAIL directed%0d_ovf: got %b, want %b", i, ovf, to[i]);
      end
`else
      if (to[i] === 1'bx) $display("unreachable");
`endif
    end
  endtask

  task automatic test_mid_reset;
    step(1'b0, 16'h1234, 16'h4321, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    n_cmp++;
    if ({cout, S} !== 17'h0) begin
      n_err++;
      $display("FAIL mid_reset: got cout=%b S=%h, want cout=0 S=0000", cout, S);
    end
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    n_cmp++;
    if ({cout, S} !== 17'h1FFFF) begin
      n_err++;
      $display("FAIL post_reset: got cout=%b S=%h, want cout=1 S=ffff", cout, S);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic        c;
    logic [16:0] w;
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (i % 8 == 0) b = ~a;
      w = ref_sum(a, b, c);
      step(1'b0, a, b, c);
      n_cmp++;
      if ({cout, S} !== w) begin
        n_err++;
        $display("FAIL random%0d: A=%h B=%h cin=%b got cout=%b S=%h, want cout=%b S=%h",
                 i, a, b, c, cout, S, w[16], w[15:0]);
      end
`ifdef CLA_OVERFLOW_EN
      n_cmp++;
      if (ovf !== ref_ovf(a, b, c)) begin
        n_err++;
        $display("FAIL random%0d_ovf: got %b, want %b", i, ovf, ref_ovf(a, b, c));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; cin = 1'b0;
    test_reset();
    test_directed();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
